idrob_ctrl: RTL
===============

# idrob_ctrl

Buffer and sequencing controller between the IF stage and the ID decoder. It accepts fetched bundles (pc, instruction, branch-prediction info) through a valid/ready handshake and holds them in a small FIFO. It presents the head entry to ID and releases it when the ROB stage accepts. It also tracks MIPS delay slots, so ID receives a correct `is_current_delayslot` for every instruction. A flush from the backend discards everything in flight.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `GHR_WIDTH`, 5: width of the PHT index field.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  discard all buffered bundles and the delay-slot state.
- `if_valid`  in  1  IF offers a bundle.
- `if_ready`  out  1  controller can accept a bundle.
- `if_pc`  in  32  fetched pc.
- `if_inst`  in  32  fetched instruction.
- `if_branch_taken`  in  1  predictor taken bit.
- `if_pht_index`  in  GHR_WIDTH  predictor index.
- `id_valid`  out  1  head bundle valid toward ID.
- `id_ready`  in  1  ROB stage accepts the decoded head this cycle.
- `id_pc`  out  32  head pc.
- `id_inst`  out  32  head instruction.
- `id_branch_taken`  out  1  head taken bit.
- `id_pht_index`  out  GHR_WIDTH  head predictor index.
- `id_is_next_delayslot`  in  1  from the ID decoder: head is a branch/jump.
- `id_is_current_delayslot`  out  1  head sits in a delay slot.
- `occupancy`  out  $clog2(DEPTH)+1  entries held.

## Operation
- Storage: circular FIFO with `wr_ptr`, `rd_ptr` of $clog2(DEPTH) bits (natural wrap) and `count` of $clog2(DEPTH)+1 bits.
- Enqueue: `if_valid && if_ready`. The bundle is written at `wr_ptr`, then `wr_ptr`+1.
- Dequeue: `id_valid && id_ready`. Then `rd_ptr`+1.
- `if_ready` = `count != DEPTH`. No enqueue-while-full, even with a simultaneous dequeue.
- `id_valid` = `count != 0`. The `id_*` bundle outputs come combinationally from the entry at `rd_ptr`.
- Count update:
  - enqueue only: +1
  - dequeue only: −1
  - both: unchanged
- Delay-slot flag `ds`:
  - On each dequeue, `ds <= id_is_next_delayslot`.
  - `id_is_current_delayslot` = `ds`.
  - `ds` holds while no dequeue occurs; a stall between a branch and its slot does not lose the flag.
- Flush has priority over enqueue and dequeue in the same cycle. The next state is `count=0`, both pointers 0, `ds=0`. `if_ready` is still driven by the current count, but the offered bundle is dropped.
- Reset (`rst`=0, asynchronous):
  - state: pointers 0, count 0, `ds` 0.
  - outputs: `id_valid` 0, `if_ready` 1, `occupancy` 0, `id_is_current_delayslot` 0.
  - `id_*` bundle outputs: 0.
- `id_*` data outputs are driven to 0 whenever `id_valid`=0.
- Reset asserted mid-transfer takes effect immediately; no partial entries survive.

## Timing
- Enqueue-to-visible latency is 1 cycle: a bundle enqueued at edge N appears on `id_*` after edge N (cycle N+1).
- Throughput is 1 bundle/cycle sustained when `id_ready`=1.
- `if_ready` and `id_valid` are pure functions of registered state; there are no combinational paths from inputs to them (except under bypass, below).
- `id_is_next_delayslot` is sampled only on a dequeue edge. ID must present it combinationally from `id_inst` within the same cycle.

## Configuration
- `IDROB_BYPASS_EN` defined: when `count==0`, `if_valid` and `id_ready` are all high, and `flush`=0, the IF bundle passes combinationally to `id_*` with `id_valid`=1.
  - The transfer counts as both enqueue and dequeue.
  - Nothing is written and `ds` updates normally.
  - In this case `id_valid` depends combinationally on `if_valid`.
- Not defined: strict 1-cycle latency; no input-to-output combinational path.

## Test plan
- Reset then single transfer: pc 0xBFC00000, `if_valid` 1 cycle → after 1 edge, `id_valid`=1 and `id_pc`=0xBFC00000. With `id_ready`=1, `occupancy` returns to 0 after the next edge.
- Fill with `DEPTH`=4, `id_ready`=0: push 5 bundles pc 0x0–0x10 → `if_ready`=0 after 4 enqueues and `occupancy`=4. The 5th bundle is held by IF and accepted only after one dequeue. Output order is 0x0, 0x4, 0x8, 0xC, 0x10.
- Delay slot: a BEQ at 0x100 dequeued with `id_is_next_delayslot`=1, followed by 3 stall cycles → the instruction at 0x104 shows `id_is_current_delayslot`=1. The next instruction, 0x108, shows 0.
- Flush with simultaneous enqueue and dequeue at `occupancy`=3 → after the edge, `occupancy`=0, `id_valid`=0 and `ds`=0. The offered bundle is not stored.
- Pointer wrap: stream 10 bundles with `id_ready` toggling 1/0 → every pc emerges once, in order, with no duplicates.
- `IDROB_BYPASS_EN`: empty FIFO, `if_valid`=`id_ready`=1, pc 0x200 → `id_pc`=0x200 in the same cycle and `occupancy` stays 0. Without the macro, it appears 1 cycle later.

Source files
------------

// File: rtl/idrob_ctrl_if.sv
// IF-to-ID bundle channel of idrob_ctrl: fetch-side valid/ready input and decode-side head output.
// master = IF/ID pipeline side, slave = the buffering controller.
interface idrob_ctrl_if #(
   parameter int GHR_WIDTH = 5
);
   logic                 if_valid;
   logic                 if_ready;
   logic [31:0]          if_pc;
   logic [31:0]          if_inst;
   logic                 if_branch_taken;
   logic [GHR_WIDTH-1:0] if_pht_index;

   logic                 id_valid;
   logic                 id_ready;
   logic [31:0]          id_pc;
   logic [31:0]          id_inst;
   logic                 id_branch_taken;
   logic [GHR_WIDTH-1:0] id_pht_index;
   logic                 id_is_next_delayslot;
   logic                 id_is_current_delayslot;

   modport master (
      output if_valid, if_pc, if_inst, if_branch_taken, if_pht_index,
      output id_ready, id_is_next_delayslot,
      input  if_ready,
      input  id_valid, id_pc, id_inst, id_branch_taken, id_pht_index, id_is_current_delayslot
   );

   modport slave (
      input  if_valid, if_pc, if_inst, if_branch_taken, if_pht_index,
      input  id_ready, id_is_next_delayslot,
      output if_ready,
      output id_valid, id_pc, id_inst, id_branch_taken, id_pht_index, id_is_current_delayslot
   );
endinterface

// File: rtl/idrob_ctrl.sv
// IF->ID bundle FIFO with MIPS delay-slot tracking and backend flush.
// Optional macro IDROB_BYPASS_EN: empty-FIFO combinational pass-through from IF to ID.
module idrob_ctrl #(
   parameter int DEPTH     = 4,
   parameter int GHR_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   idrob_ctrl_if.slave              bus,
   output logic [$clog2(DEPTH):0]   occupancy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
   localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

   logic [31:0]          pc_mem_r   [DEPTH];
   logic [31:0]          inst_mem_r [DEPTH];
   logic                 bt_mem_r   [DEPTH];
   logic [GHR_WIDTH-1:0] pht_mem_r  [DEPTH];

   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          ds_r;

   logic empty_s;
   logic full_s;
   logic bypass_s;
   logic enq_s;
   logic deq_s;
   logic ds_upd_s;

   assign empty_s = (count_r == {CW{1'b0}});
   assign full_s  = (count_r == FULL_C);

   // Bypass qualifier: only ever asserted in the pass-through build.
   always_comb begin
      bypass_s = 1'b0;
`ifdef IDROB_BYPASS_EN
      if (empty_s && bus.if_valid && bus.id_ready && !flush) begin
         bypass_s = 1'b1;
      end else begin
         bypass_s = 1'b0;
      end
`endif
   end

   assign bus.if_ready = !full_s;
   assign bus.id_valid = !empty_s || bypass_s;
   assign occupancy    = count_r;
   assign bus.id_is_current_delayslot = ds_r;

   // A bypassed transfer enqueues and dequeues at once, so storage sees neither.
   assign enq_s    = bus.if_valid && !full_s && !bypass_s;
   assign deq_s    = !empty_s && bus.id_ready;
   assign ds_upd_s = bus.id_valid && bus.id_ready;

   // Pointer, occupancy and delay-slot state; flush outranks any transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         ds_r     <= 1'b0;
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         ds_r     <= 1'b0;
      end else begin
         if (enq_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         else       wr_ptr_r <= wr_ptr_r;
         if (deq_s) rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
         else       rd_ptr_r <= rd_ptr_r;
         case ({enq_s, deq_s})
            2'b10:   count_r <= count_r + CNT_ONE_C;
            2'b01:   count_r <= count_r - CNT_ONE_C;
            default: count_r <= count_r;
         endcase
         // The flag survives stalls: it only moves when the head leaves.
         if (ds_upd_s) ds_r <= bus.id_is_next_delayslot;
         else          ds_r <= ds_r;
      end
   end

   // Bundle storage; cleared on reset so no partial entry can reappear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_r[i]   <= 32'h0000_0000;
            inst_mem_r[i] <= 32'h0000_0000;
            bt_mem_r[i]   <= 1'b0;
            pht_mem_r[i]  <= {GHR_WIDTH{1'b0}};
         end
      end else if (enq_s && !flush) begin
         pc_mem_r[wr_ptr_r]   <= bus.if_pc;
         inst_mem_r[wr_ptr_r] <= bus.if_inst;
         bt_mem_r[wr_ptr_r]   <= bus.if_branch_taken;
         pht_mem_r[wr_ptr_r]  <= bus.if_pht_index;
      end else begin
         pc_mem_r[wr_ptr_r]   <= pc_mem_r[wr_ptr_r];
         inst_mem_r[wr_ptr_r] <= inst_mem_r[wr_ptr_r];
         bt_mem_r[wr_ptr_r]   <= bt_mem_r[wr_ptr_r];
         pht_mem_r[wr_ptr_r]  <= pht_mem_r[wr_ptr_r];
      end
   end

   // Head bundle toward ID, forced to zero whenever nothing is valid.
   always_comb begin
      bus.id_pc           = 32'h0000_0000;
      bus.id_inst         = 32'h0000_0000;
      bus.id_branch_taken = 1'b0;
      bus.id_pht_index    = {GHR_WIDTH{1'b0}};
      if (bypass_s) begin
         bus.id_pc           = bus.if_pc;
         bus.id_inst         = bus.if_inst;
         bus.id_branch_taken = bus.if_branch_taken;
         bus.id_pht_index    = bus.if_pht_index;
      end else if (!empty_s) begin
         bus.id_pc           = pc_mem_r[rd_ptr_r];
         bus.id_inst         = inst_mem_r[rd_ptr_r];
         bus.id_branch_taken = bt_mem_r[rd_ptr_r];
         bus.id_pht_index    = pht_mem_r[rd_ptr_r];
      end else begin
         bus.id_pc           = 32'h0000_0000;
         bus.id_inst         = 32'h0000_0000;
         bus.id_branch_taken = 1'b0;
         bus.id_pht_index    = {GHR_WIDTH{1'b0}};
      end
   end
endmodule
